complex_pair_gather: RTL and testbench

//  Upstream feeder for complex_subtract.
//  - Takes a stream of packed complex samples (real in the upper half, imag in the lower half).
//  - Pairs consecutive samples as (a = first, b = second).
//  - Buffers completed pairs in a small FIFO.
//  - Issues one pair per cycle as a/b plus a single-cycle out_valid that drives the subtractor's in_valid.

---
 rtl/complex_pair_gather.sv | 109 ++++++++++
 tb/tb_complex_pair_gather.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/complex_pair_gather.sv
// complex_pair_gather: pairs consecutive packed complex samples into (a, b) and buffers them in a FIFO.
// Optional feature macro COMPLEX_PAIR_SYNC_EN adds s_first / sync_err for 'a'-sample realignment.
module complex_pair_gather #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [BITS-1:0]        s_data,
`ifdef COMPLEX_PAIR_SYNC_EN
    input  logic                   s_first,
    output logic                   sync_err,
`endif
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [BITS-1:0]        a,
    output logic [BITS-1:0]        b,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, HAVE_A} state_t;

    state_t            state;
    logic [BITS-1:0]   hold;
    logic [2*BITS-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              accept;
    logic              push;
    logic              pop;
    logic              resync;

    // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
    always_comb begin
        pop     = out_ready && (count != '0);
        s_ready = !flush && ((state == IDLE) || (count < CW'(DEPTH)) || pop);
        accept  = s_valid && s_ready;
`ifdef COMPLEX_PAIR_SYNC_EN
        resync  = accept && (state == HAVE_A) && s_first;
`else
        resync  = 1'b0;
`endif
        push    = accept && (state == HAVE_A) && !resync;
    end

    // Pairing FSM: a held 'a' sample waits here until its 'b' arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
`ifdef COMPLEX_PAIR_SYNC_EN
            sync_err <= 1'b0;
`endif
        end else begin
`ifdef COMPLEX_PAIR_SYNC_EN
            sync_err <= resync;
`endif
            if (flush) begin
                state <= IDLE;
            end else if (accept) begin
                if ((state == IDLE) || resync) begin
                    hold  <= s_data;
                    state <= HAVE_A;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; count and the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {hold, s_data};
        end
    end

    // A pop at full reads the old head while the same-cycle push overwrites that slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                {a, b} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_complex_pair_gather.sv
// Randomized and directed bench for complex_pair_gather against a queue-based pairing model.
// Covers the COMPLEX_PAIR_SYNC_EN ports and realignment when that macro is defined.
module tb_complex_pair_gather;
    localparam int BITS  = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef COMPLEX_PAIR_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [BITS-1:0] s_data;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [CW-1:0]   count;
    logic            s_first;
    logic            sync_err;

    complex_pair_gather #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
`ifdef COMPLEX_PAIR_SYNC_EN
        .s_first   (s_first),
        .sync_err  (sync_err),
`endif
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a         (a),
        .b         (b),
        .count     (count)
    );

`ifndef COMPLEX_PAIR_SYNC_EN
    assign sync_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: an optional held 'a' sample plus a queue of complete pairs.
    bit                m_have;
    logic [BITS-1:0]   m_hold;
    logic [2*BITS-1:0] m_q[$];
    logic [BITS-1:0]   m_a;
    logic [BITS-1:0]   m_b;
    bit                m_ov;
    bit                m_serr;

    task automatic model_clear();
        m_have = 1'b0;
        m_hold = '0;
        m_q.delete();
        m_a    = '0;
        m_b    = '0;
        m_ov   = 1'b0;
        m_serr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0; s_data = '0; flush = 1'b0; out_ready = 1'b0; s_first = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_sync_err", sync_err, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check s_ready, advance the model, check registered outputs.
    task automatic step(input bit v, input logic [BITS-1:0] d, input bit f, input bit r, input bit first);
        bit pop;
        bit acc;
        bit exp_ready;
        @(negedge clk);
        s_valid = v; s_data = d; flush = f; out_ready = r; s_first = first;
        #1;
        pop       = r && (m_q.size() > 0);
        exp_ready = !f && (!m_have || (m_q.size() < DEPTH) || pop);
        check("s_ready", s_ready, exp_ready);
        acc  = v && exp_ready;
        m_ov = pop;
        if (pop) {m_a, m_b} = m_q.pop_front();
        m_serr = 1'b0;
        if (f) begin
            m_have = 1'b0;
        end else if (acc) begin
            if (!m_have) begin
                m_hold = d;
                m_have = 1'b1;
            end else if (SYNC && first) begin
                m_hold = d;
                m_serr = 1'b1;
            end else begin
                m_q.push_back({m_hold, d});
                m_have = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        check("a", a, m_a);
        check("b", b, m_b);
        check("count", count, m_q.size());
        check("sync_err", sync_err, m_serr);
    endtask

    task automatic idle_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, r, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; flush = 1'b0; out_ready = 1'b0; s_first = 1'b0;
        model_clear();
        do_reset();

        // Single pair, out_valid one edge after the second accept.
        step(1'b1, 16'h0102, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0304, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("pair_basic", {out_valid, a, b}, {1'b1, 32'h0102_0304});
        idle_cycles(2, 1'b1);

        // Backpressure: five pairs at DEPTH=4, then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, BITS'(16'h1000 + i), 1'b0, 1'b0, 1'b0);
        end
        check("bp_count_full", count, DEPTH);
        step(1'b1, 16'h1009, 1'b0, 1'b1, 1'b0);
        idle_cycles(7, 1'b1);

        // Flush discards the held half-pair.
        do_reset();
        step(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("flush_pair", {out_valid, a, b}, {1'b1, 32'h1111_2222});
        idle_cycles(2, 1'b1);

        // Fill to DEPTH, then stream continuously while draining across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, BITS'(16'h2000 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, BITS'(16'h3000 + i), 1'b0, 1'b1, 1'b0);
        idle_cycles(6, 1'b1);

`ifdef COMPLEX_PAIR_SYNC_EN
        do_reset();
        step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        check("sync_err_pulse", sync_err, 1);
        step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("sync_pair", {out_valid, a, b}, {1'b1, 32'h0002_0003});
        idle_cycles(2, 1'b1);
`endif

        // Random traffic with an asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, BITS'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            if (i == 300) do_reset();
        end
        idle_cycles(8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
